// File: rtl/filter_pkg.sv
// Shared types and widths for the 7-tap filter coefficient/sample sequencer.
package filter_pkg;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        LOAD,
        FLUSH,
        DONE
    } state_e;

    localparam int unsigned COEF_W    = 8;
    localparam int unsigned SAMP_W    = 8;
    localparam int unsigned ADDR_W    = 3;
    localparam int unsigned NTAPS_MAX = 7;

endpackage

// File: rtl/filter_cfg_ctrl.sv
// Input-side sequencer for the filter: passes samples, and on reload stalls,
// drains, writes NTAPS coefficients in address order, then optionally flushes.
module filter_cfg_ctrl
    import filter_pkg::*;
#(
    parameter int unsigned NTAPS      = 7,
    parameter int unsigned FILTER_LAT = 2,
    parameter int unsigned FLUSH_EN   = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic [COEF_W-1:0] cfg_data,
    output logic              cfg_ready,
    input  logic              s_valid,
    input  logic [SAMP_W-1:0] s_data,
    output logic              s_ready,
    output logic              x_valid,
    output logic [SAMP_W-1:0] x,
    output logic              b_valid,
    output logic [COEF_W-1:0] b,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int unsigned DRAIN_W = (FILTER_LAT == 0) ? 1 : $clog2(FILTER_LAT + 1);
    // One down-counter serves both DRAIN and FLUSH, so it must fit either load value.
    localparam int unsigned CNT_W   = (DRAIN_W > 3) ? DRAIN_W : 3;

    localparam logic [CNT_W-1:0]  DRAIN_LD  = CNT_W'(FILTER_LAT);
    localparam logic [CNT_W-1:0]  FLUSH_LD  = CNT_W'(NTAPS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NTAPS - 1);
    localparam state_e            LOAD_NXT  = (FLUSH_EN != 0) ? FLUSH : DONE;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                x_valid_q, x_valid_d;
    logic [SAMP_W-1:0]   x_q, x_d;
    logic                b_valid_q, b_valid_d;
    logic [COEF_W-1:0]   b_q, b_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_q, err_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            idx_q     <= '0;
            x_valid_q <= 1'b0;
            x_q       <= '0;
            b_valid_q <= 1'b0;
            b_q       <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            x_valid_q <= x_valid_d;
            x_q       <= x_d;
            b_valid_q <= b_valid_d;
            b_q       <= b_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        x_valid_d = 1'b0;
        x_d       = x_q;
        b_valid_d = 1'b0;
        b_d       = b_q;
        addr_d    = addr_q;
        err_d     = cfg_start && (state_q != RUN);
        s_ready   = 1'b0;
        cfg_ready = 1'b0;
        busy      = (state_q != RUN);
        cfg_done  = 1'b0;

        case (state_q)
            RUN: begin
                // cfg_start wins over a sample offered in the same cycle.
                s_ready = !cfg_start;
                if (cfg_start) begin
                    idx_d = '0;
                    if (FILTER_LAT == 0) begin
                        state_d = LOAD;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_LD;
                    end
                end else if (s_valid) begin
                    x_valid_d = 1'b1;
                    x_d       = s_data;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    b_valid_d = 1'b1;
                    b_d       = cfg_data;
                    addr_d    = idx_q;
                    idx_d     = idx_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = LOAD_NXT;
                        cnt_d   = FLUSH_LD;
                        idx_d   = '0;
                    end
                end
            end
            FLUSH: begin
                x_valid_d = 1'b1;
                x_d       = '0;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                cfg_done = 1'b1;
                state_d  = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign x_valid = x_valid_q;
    assign x       = x_q;
    assign b_valid = b_valid_q;
    assign b       = b_q;
    assign addr    = addr_q;
    assign cfg_err = err_q;

endmodule
